// File: rtl/tile_judge.sv
// tile_judge: judges lane-key presses against the bottom tile row, issues the
// shift request that advances the tile field, and keeps score and lives.
module tile_judge #(
  parameter int SCORE_W = 10,
  parameter int LIVES   = 3,
  parameter int LIFE_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               tick,
  input  logic [3:0]         key,
  input  logic [1:0]         bottom_lane,
  output logic               shift,
  output logic [SCORE_W-1:0] score,
  output logic [LIFE_W-1:0]  lives,
  output logic               playing,
  output logic               game_over,
  output logic               hit,
  output logic               miss
);

  typedef enum logic [1:0] {IDLE, PLAY, SETTLE, OVER} state_t;

  localparam logic [LIFE_W-1:0]  LIVES_INIT = LIFE_W'(LIVES);
  localparam logic [LIFE_W-1:0]  ONE_LIFE   = LIFE_W'(1);
  localparam logic [SCORE_W-1:0] ONE_POINT  = SCORE_W'(1);

  state_t               state, state_nx;
  logic [3:0]           key_prev;
  logic [3:0]           rise;
  logic [2:0]           rise_cnt;
  logic                 good_press;
  logic [SCORE_W-1:0]   score_nx;
  logic [LIFE_W-1:0]    lives_nx;
  logic                 shift_nx, hit_nx, miss_nx;

  // Rising edges on the lane keys and how many arrived this cycle
  always_comb begin
    rise     = key & ~key_prev;
    rise_cnt = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      rise_cnt = rise_cnt + {2'b00, rise[i]};
    end
    good_press = (rise_cnt == 3'd1) && rise[bottom_lane];
  end

  // Next-state, scoring and pulse decisions
  always_comb begin
    state_nx = state;
    score_nx = score;
    lives_nx = lives;
    shift_nx = 1'b0;
    hit_nx   = 1'b0;
    miss_nx  = 1'b0;
    unique case (state)
      IDLE, OVER: begin
        if (start) begin
          score_nx = '0;
          lives_nx = LIVES_INIT;
          state_nx = PLAY;
        end
      end
      PLAY: begin
        if (good_press) begin
          hit_nx   = 1'b1;
          shift_nx = 1'b1;
          if (score != '1) score_nx = score + ONE_POINT;
          state_nx = SETTLE;
        end else if (rise_cnt != 3'd0) begin
          miss_nx  = 1'b1;
          lives_nx = lives - ONE_LIFE;
          if (lives == ONE_LIFE) state_nx = OVER;
        end else if (tick) begin
          miss_nx  = 1'b1;
          lives_nx = lives - ONE_LIFE;
          if (lives == ONE_LIFE) begin
            state_nx = OVER;
          end else begin
            shift_nx = 1'b1;
            state_nx = SETTLE;
          end
        end
      end
      SETTLE: begin
        state_nx = PLAY;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      score     <= '0;
      lives     <= '0;
      shift     <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      playing   <= 1'b0;
      game_over <= 1'b0;
      key_prev  <= '1;
    end else begin
      state     <= state_nx;
      score     <= score_nx;
      lives     <= lives_nx;
      shift     <= shift_nx;
      hit       <= hit_nx;
      miss      <= miss_nx;
      playing   <= (state_nx == PLAY) || (state_nx == SETTLE);
      game_over <= (state_nx == OVER);
      key_prev  <= key;
    end
  end

endmodule

// File: tb/tb_tile_judge.sv
// tb_tile_judge: directed scenarios plus randomized play checked against a
// rule-level model of the game.
module tb_tile_judge;

  localparam int SW   = 4;
  localparam int LV   = 3;
  localparam int LW   = 2;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset, start, tick;
  logic [3:0]    key;
  logic [1:0]    bottom_lane;
  logic          shift, hit, miss, playing, game_over;
  logic [SW-1:0] score;
  logic [LW-1:0] lives;

  int n_checks = 0;
  int n_fail   = 0;

  tile_judge #(.SCORE_W(SW), .LIVES(LV), .LIFE_W(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .key(key),
    .bottom_lane(bottom_lane), .shift(shift), .score(score), .lives(lives),
    .playing(playing), .game_over(game_over), .hit(hit), .miss(miss)
  );

  always #5 clk = ~clk;

  // Game model: what the judge should show after each clock edge
  typedef enum {M_IDLE, M_PLAY, M_SETTLE, M_OVER} mode_t;
  mode_t    m_mode  = M_IDLE;
  int       m_score = 0;
  int       m_lives = 0;
  logic [3:0] m_prev = 4'b1111;
  bit       m_shift, m_hit, m_miss;

  // Advance one clock, update the model from the inputs sampled at the edge
  task automatic cyc();
    logic [3:0] pressed;
    int npress;
    @(posedge clk);
    pressed = key & ~m_prev;
    npress  = $countones(pressed);
    m_shift = 0; m_hit = 0; m_miss = 0;
    if (reset) begin
      m_mode = M_IDLE; m_score = 0; m_lives = 0; m_prev = 4'b1111;
    end else begin
      if (m_mode == M_IDLE || m_mode == M_OVER) begin
        if (start) begin m_score = 0; m_lives = LV; m_mode = M_PLAY; end
      end else if (m_mode == M_SETTLE) begin
        m_mode = M_PLAY;
      end else begin
        if (npress == 1 && pressed[bottom_lane]) begin
          m_hit = 1; m_shift = 1;
          m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
          m_mode = M_SETTLE;
        end else if (npress > 0 || tick) begin
          m_miss = 1;
          m_lives = m_lives - 1;
          if (m_lives == 0) m_mode = M_OVER;
          else if (npress == 0) begin m_shift = 1; m_mode = M_SETTLE; end
        end
      end
      m_prev = key;
    end
    #1;
  endtask

  task automatic reset_start();
    reset = 1; start = 0; tick = 0; key = 4'b0000; bottom_lane = 2'd0;
    cyc();
    reset = 0; start = 1;
    cyc();
    start = 0;
  endtask

  task automatic test_reset();
    reset = 1; start = 0; tick = 0; key = 4'b1111; bottom_lane = 2'd0;
    cyc(); cyc();
    n_checks++;
    if ({shift, hit, miss, playing, game_over, lives, score} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got shift%b hit%b miss%b play%b over%b lives%0d score%0d, want all 0",
               shift, hit, miss, playing, game_over, lives, score);
    end
    reset = 0; start = 1;
    cyc();
    start = 0;
    n_checks++;
    if ({playing, game_over, lives, score} !== {1'b1, 1'b0, LW'(LV), SW'(0)}) begin
      n_fail++;
      $display("FAIL start_load: got play%b over%b lives%0d score%0d, want play1 over0 lives%0d score0",
               playing, game_over, lives, score, LV);
    end
    cyc();
    n_checks++;
    if ({hit, miss} !== 2'b00) begin
      n_fail++;
      $display("FAIL held_keys_after_reset: got hit%b miss%b, want 00", hit, miss);
    end
    key = 4'b0000;
    cyc();
  endtask

  task automatic test_hit();
    bottom_lane = 2'd2; key = 4'b0100;
    cyc();
    n_checks++;
    if ({shift, hit, miss, score, lives} !== {3'b110, SW'(1), LW'(3)}) begin
      n_fail++;
      $display("FAIL hit_correct: got shift%b hit%b miss%b score%0d lives%0d, want 110 score1 lives3",
               shift, hit, miss, score, lives);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++;
      if ({shift, hit, miss} !== 3'b000) begin
        n_fail++;
        $display("FAIL held_no_retrigger[%0d]: got shift%b hit%b miss%b, want 000", i, shift, hit, miss);
      end
    end
    key = 4'b0000;
    cyc();
  endtask

  task automatic test_wrong_lane();
    bottom_lane = 2'd1; key = 4'b1000;
    cyc();
    n_checks++;
    if ({shift, hit, miss, lives, playing} !== {3'b001, LW'(2), 1'b1}) begin
      n_fail++;
      $display("FAIL wrong_lane: got shift%b hit%b miss%b lives%0d play%b, want 001 lives2 play1",
               shift, hit, miss, lives, playing);
    end
    key = 4'b0010;
    cyc();
    n_checks++;
    if ({shift, hit, miss, score} !== {3'b110, SW'(2)}) begin
      n_fail++;
      $display("FAIL hit_after_miss: got shift%b hit%b miss%b score%0d, want 110 score2",
               shift, hit, miss, score);
    end
    key = 4'b0000;
    cyc(); cyc();
  endtask

  task automatic test_timeout();
    reset_start();
    for (int t = 0; t < 3; t++) begin
      tick = 1;
      cyc();
      tick = 0;
      n_checks++;
      if ({shift, miss, hit, lives} !== {(t < 2), 2'b10, LW'(2 - t)}) begin
        n_fail++;
        $display("FAIL timeout[%0d]: got shift%b miss%b hit%b lives%0d, want shift%0d miss1 hit0 lives%0d",
                 t, shift, miss, hit, lives, (t < 2), 2 - t);
      end
      cyc();
    end
    n_checks++;
    if ({game_over, playing, miss, shift, lives} !== {4'b1000, LW'(0)}) begin
      n_fail++;
      $display("FAIL game_over: got over%b play%b miss%b shift%b lives%0d, want over1 play0 miss0 shift0 lives0",
               game_over, playing, miss, shift, lives);
    end
  endtask

  task automatic test_tick_collide();
    start = 1;
    cyc();
    start = 0;
    n_checks++;
    if ({score, lives, playing, game_over} !== {SW'(0), LW'(LV), 2'b10}) begin
      n_fail++;
      $display("FAIL restart_from_over: got score%0d lives%0d play%b over%b, want score0 lives%0d play1 over0",
               score, lives, playing, game_over, LV);
    end
    bottom_lane = 2'd3; key = 4'b1000; tick = 1;
    cyc();
    n_checks++;
    if ({shift, hit, miss, lives, score} !== {3'b110, LW'(3), SW'(1)}) begin
      n_fail++;
      $display("FAIL hit_with_tick: got shift%b hit%b miss%b lives%0d score%0d, want 110 lives3 score1",
               shift, hit, miss, lives, score);
    end
    cyc();
    tick = 0;
    n_checks++;
    if ({shift, hit, miss, lives} !== {3'b000, LW'(3)}) begin
      n_fail++;
      $display("FAIL tick_in_settle: got shift%b hit%b miss%b lives%0d, want 000 lives3",
               shift, hit, miss, lives);
    end
    cyc();
    n_checks++;
    if ({shift, hit, miss} !== 3'b000) begin
      n_fail++;
      $display("FAIL after_settle_quiet: got shift%b hit%b miss%b, want 000", shift, hit, miss);
    end
    key = 4'b0000;
    cyc();
  endtask

  task automatic test_double_edge();
    bottom_lane = 2'd0; key = 4'b0101;
    cyc();
    n_checks++;
    if ({shift, hit, miss, lives} !== {3'b001, LW'(2)}) begin
      n_fail++;
      $display("FAIL double_edge: got shift%b hit%b miss%b lives%0d, want 001 lives2",
               shift, hit, miss, lives);
    end
    key = 4'b0000;
    cyc();
    key = 4'b0001;
    cyc();
    bottom_lane = 2'd2; key = 4'b0101;
    cyc();
    n_checks++;
    if ({shift, hit, miss} !== 3'b000) begin
      n_fail++;
      $display("FAIL press_in_settle: got shift%b hit%b miss%b, want 000", shift, hit, miss);
    end
    cyc();
    n_checks++;
    if ({shift, hit, miss, score} !== {3'b000, SW'(2)}) begin
      n_fail++;
      $display("FAIL settle_edge_discarded: got shift%b hit%b miss%b score%0d, want 000 score2",
               shift, hit, miss, score);
    end
    key = 4'b0000;
    cyc();
  endtask

  task automatic test_reset_mid();
    reset_start();
    for (int i = 0; i < 5; i++) begin
      bottom_lane = 2'(i); key = 4'b0001 << (i % 4);
      cyc();
      key = 4'b0000;
      cyc();
    end
    n_checks++;
    if (score !== SW'(5)) begin
      n_fail++;
      $display("FAIL score_five: got %0d, want 5", score);
    end
    reset = 1; tick = 1; key = 4'b0001; bottom_lane = 2'd0;
    cyc();
    reset = 0; tick = 0; key = 4'b0000;
    n_checks++;
    if ({shift, hit, miss, playing, game_over, lives, score} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_game: got shift%b hit%b miss%b play%b over%b lives%0d score%0d, want all 0",
               shift, hit, miss, playing, game_over, lives, score);
    end
    start = 1;
    cyc();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      key = 4'b0010;
      cyc();
      key = 4'b0000;
      cyc();
    end
    start = 1;
    cyc();
    start = 0;
    n_checks++;
    if ({score, lives, playing, game_over} !== {SW'(0), LW'(LV), 2'b10}) begin
      n_fail++;
      $display("FAIL start_from_over: got score%0d lives%0d play%b over%b, want score0 lives%0d play1 over0",
               score, lives, playing, game_over, LV);
    end
  endtask

  task automatic test_saturation();
    int want;
    reset_start();
    for (int i = 0; i < SMAX + 3; i++) begin
      bottom_lane = 2'($urandom_range(0, 3));
      key = 4'b0001 << bottom_lane;
      cyc();
      key = 4'b0000;
      want = (i + 1 > SMAX) ? SMAX : i + 1;
      n_checks++;
      if ({hit, shift, score} !== {2'b11, SW'(want)}) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got hit%b shift%b score%0d, want hit1 shift1 score%0d",
                 i, hit, shift, score, want);
      end
      cyc();
    end
  endtask

  task automatic test_random();
    logic [4:0] got_bits, want_bits;
    reset_start();
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      start       = ($urandom_range(0, 7) == 0);
      tick        = ($urandom_range(0, 3) == 0);
      bottom_lane = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: key = 4'b0000;
        1: key = 4'b0001 << bottom_lane;
        2: key = key;
        default: key = 4'($urandom);
      endcase
      cyc();
      got_bits  = {shift, hit, miss, playing, game_over};
      want_bits = {m_shift, m_hit, m_miss, (m_mode == M_PLAY || m_mode == M_SETTLE), (m_mode == M_OVER)};
      n_checks++;
      if (got_bits !== want_bits || score !== SW'(m_score) || lives !== LW'(m_lives)) begin
        n_fail++;
        $display("FAIL random[%0d]: got sh/hit/miss/play/over=%b score%0d lives%0d, want %b score%0d lives%0d",
                 i, got_bits, score, lives, want_bits, m_score, m_lives);
      end
    end
    reset = 0; start = 0; tick = 0; key = 4'b0000;
  endtask

  initial begin
    reset = 1; start = 0; tick = 0; key = 4'b0000; bottom_lane = 2'd0;
    test_reset();
    test_hit();
    test_wrong_lane();
    test_timeout();
    test_tick_collide();
    test_double_edge();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
